// File: rtl/seg_mux_driver.sv
// Time-multiplexed seven-segment driver: hex decode, blanking, decimal points,
// leading-zero suppression, dead-time gap and frame-synchronous double buffering.
module seg_mux_driver #(
    parameter int DIGITS         = 2,
    parameter int REFRESH_DIV    = 1024,
    parameter int DEADTIME       = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] hexVals,
    input  logic [DIGITS-1:0]   dpIn,
    input  logic [DIGITS-1:0]   blankIn,
    input  logic                lzs,
    input  logic                load,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   en,
    output logic                frameStart
);

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > DEADTIME) ? REFRESH_DIV : DEADTIME;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);

    localparam logic [0:0] SHOW = 1'b0;
    localparam logic [0:0] GAP  = 1'b1;

    localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_POL  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] EN_POL  = {DIGITS{EN_ACTIVE_LOW}};

    logic [0:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;

    logic [4*DIGITS-1:0] pHex;
    logic [DIGITS-1:0]   pDp;
    logic [DIGITS-1:0]   pBlank;
    logic                pLzs;

    logic [4*DIGITS-1:0] aHex;
    logic [DIGITS-1:0]   aDp;
    logic [DIGITS-1:0]   aBlank;
    logic                aLzs;

    logic                showTc;
    logic                gapTc;
    logic                advance;
    logic                wrap;
    logic [IDX_W-1:0]    idxNext;

    logic [3:0]          curNib;
    logic                curBlank;
    logic                curDp;
    logic                upperZero;
    logic                lzDark;
    logic                dark;
    logic [6:0]          segOn;
    logic                dpOn;
    logic [DIGITS-1:0]   enOn;

    // Active-high segment pattern, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] decodeHex(input logic [3:0] nib);
        logic [6:0] pattern;
        case (nib)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h67;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

    // With no dead time the SHOW terminal count advances the digit directly.
    always_comb begin
        showTc  = (state == SHOW) && (cnt == SHOW_TC);
        gapTc   = (state == GAP) && (cnt == GAP_TC);
        advance = gapTc || (showTc && (DEADTIME == 0));
        wrap    = advance && (idx == LAST_IDX);
        idxNext = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SHOW;
            idx   <= '0;
            cnt   <= '0;
        end else if (state == SHOW) begin
            if (showTc) begin
                cnt <= '0;
                if (DEADTIME == 0) begin
                    idx <= idxNext;
                end else begin
                    state <= GAP;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            if (gapTc) begin
                cnt   <= '0;
                idx   <= idxNext;
                state <= SHOW;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A load on the commit edge goes straight into the active buffer as well.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pHex   <= '0;
            pDp    <= '0;
            pBlank <= '0;
            pLzs   <= 1'b0;
            aHex   <= '0;
            aDp    <= '0;
            aBlank <= '0;
            aLzs   <= 1'b0;
        end else begin
            if (load) begin
                pHex   <= hexVals;
                pDp    <= dpIn;
                pBlank <= blankIn;
                pLzs   <= lzs;
            end
            if (wrap) begin
                aHex   <= load ? hexVals : pHex;
                aDp    <= load ? dpIn    : pDp;
                aBlank <= load ? blankIn : pBlank;
                aLzs   <= load ? lzs     : pLzs;
            end
        end
    end

    // Scan from the top digit down so upperZero covers idx..DIGITS-1 when idx is reached.
    always_comb begin
        curNib    = 4'h0;
        curBlank  = 1'b0;
        curDp     = 1'b0;
        upperZero = 1'b1;
        lzDark    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upperZero = upperZero && (aHex[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                curNib   = aHex[4*i +: 4];
                curBlank = aBlank[i];
                curDp    = aDp[i];
                lzDark   = aLzs && (i != 0) && upperZero;
            end
        end
        dark = curBlank || lzDark;
    end

    always_comb begin
        segOn = 7'h00;
        dpOn  = 1'b0;
        enOn  = '0;
        if (state == SHOW) begin
            if (!dark) begin
                segOn = decodeHex(curNib);
                dpOn  = curDp;
            end
            for (int i = 0; i < DIGITS; i++) begin
                enOn[i] = (idx == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg        <= SEG_POL;
            dp         <= DP_POL;
            en         <= EN_POL;
            frameStart <= 1'b0;
        end else begin
            seg        <= segOn ^ SEG_POL;
            dp         <= dpOn ^ DP_POL;
            en         <= enOn ^ EN_POL;
            frameStart <= (state == SHOW) && (idx == '0) && (cnt == '0);
        end
    end

endmodule
